// File: rtl/audio_clk_gen.sv
// rtl/audio_clk_gen.sv - NCO-based MCLK/BCLK/LRCLK generator (optional AUDIO_CLK_FRAME_CNT_EN frame counter)
module audio_clk_gen #(
    parameter int unsigned      ACC_W         = 32,
    parameter logic [ACC_W-1:0] INC_DEFAULT   = 32'd3166593488,
    parameter int unsigned      MCLK_PER_BCLK = 4,
    parameter int unsigned      SLOT_W        = 32,
    parameter int unsigned      LOCK_FRAMES   = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ACC_W-1:0] inc_in,
    input  logic             inc_load,
    output logic             mclk,
    output logic             bclk,
    output logic             lrclk,
    output logic             bclk_fall,
    output logic             frame_start,
`ifdef AUDIO_CLK_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             locked
);

    localparam int unsigned DIV_W  = $clog2(MCLK_PER_BCLK);
    localparam int unsigned BIT_W  = $clog2(2 * SLOT_W);
    localparam int unsigned LOCK_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(MCLK_PER_BCLK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FRAMES);

    logic [ACC_W-1:0]  acc_q, acc_d, inc_q, inc_d;
    logic [ACC_W:0]    sum;
    logic              tick;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              mclk_q, mclk_d, bclk_q, bclk_d, lrclk_q, lrclk_d;
    logic              bclk_fall_q, bclk_fall_d, frame_start_q, frame_start_d;
`ifdef AUDIO_CLK_FRAME_CNT_EN
    logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

    assign sum  = {1'b0, acc_q} + {1'b0, inc_q};
    assign tick = sum[ACC_W];

    always_comb begin
        acc_d         = acc_q;
        inc_d         = inc_load ? inc_in : inc_q;
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        mclk_d        = mclk_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        bclk_fall_d   = 1'b0;
        frame_start_d = 1'b0;
`ifdef AUDIO_CLK_FRAME_CNT_EN
        frame_cnt_d   = frame_cnt_q;
`endif
        if (!enable) begin
            // bit_cnt is parked on the last slot bit so the first fall opens a frame
            acc_d      = '0;
            div_cnt_d  = '0;
            bit_cnt_d  = BIT_LAST;
            lock_cnt_d = '0;
            mclk_d     = 1'b0;
            bclk_d     = 1'b0;
            lrclk_d    = 1'b0;
`ifdef AUDIO_CLK_FRAME_CNT_EN
            frame_cnt_d = '0;
`endif
        end else begin
            acc_d = sum[ACC_W-1:0];
            if (tick) begin
                mclk_d = ~mclk_q;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bclk_d    = ~bclk_q;
                    if (bclk_q) begin
                        bclk_fall_d   = 1'b1;
                        bit_cnt_d     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                        lrclk_d       = (bit_cnt_d >= BIT_W'(SLOT_W));
                        frame_start_d = (bit_cnt_d == '0);
`ifdef AUDIO_CLK_FRAME_CNT_EN
                        if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            if (frame_start_q && lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
        end
        if (inc_load) lock_cnt_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            acc_q         <= '0;
            inc_q         <= INC_DEFAULT;
            div_cnt_q     <= '0;
            bit_cnt_q     <= BIT_LAST;
            lock_cnt_q    <= '0;
            mclk_q        <= 1'b0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            bclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef AUDIO_CLK_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            acc_q         <= acc_d;
            inc_q         <= inc_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            mclk_q        <= mclk_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            bclk_fall_q   <= bclk_fall_d;
            frame_start_q <= frame_start_d;
`ifdef AUDIO_CLK_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign mclk        = mclk_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign bclk_fall   = bclk_fall_q;
    assign frame_start = frame_start_q;
    assign locked      = (lock_cnt_q == LOCK_MAX) && enable && (inc_q != '0);
`ifdef AUDIO_CLK_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
- Parametrised, all-digital successor to the fixed 18.432 MHz audio PLL wrapper.
- A phase-accumulator NCO driven from refclk produces MCLK. Integer dividers then derive BCLK and LRCLK for an I2S-style serialiser.
- The increment is loadable at run time, so one block covers 48k/44.1k-family rates without regenerating a PLL.
- Sits between the board reference clock and the audio codec interface. Also provides single-cycle strobes for the serialiser.

Parameters:
- ACC_W, 32: phase accumulator width (8..48).
- INC_DEFAULT, 3166593488: increment after reset. Gives a tick rate of 36.864 MHz (MCLK 18.432 MHz) at refclk 50 MHz.
- MCLK_PER_BCLK, 4: MCLK periods per BCLK period (even, >=2).
- SLOT_W, 32: BCLK periods per channel slot (>=2). One frame = 2*SLOT_W BCLK periods.
- LOCK_FRAMES, 2: frames counted before locked asserts (>=1).

Ports:
- refclk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: reset, synchronous and active-low.
- enable, input, 1: run control; low = synchronous stop.
- inc_in, input, ACC_W: new NCO increment.
- inc_load, input, 1: one-cycle strobe that latches inc_in.
- mclk, output, 1: master clock (register output).
- bclk, output, 1: bit clock (register output).
- lrclk, output, 1: word select; 0 = left, 1 = right.
- bclk_fall, output, 1: one-cycle pulse in the cycle bclk goes 1->0.
- frame_start, output, 1: one-cycle pulse at the first left-slot bclk falling edge.
- locked, output, 1: clocks stable at the current increment.

Behaviour:
- Reset (rst==0 at a refclk edge):
  - acc, div_cnt, bit_cnt, lock_cnt are cleared.
  - inc_q is set to INC_DEFAULT.
  - All outputs are 0.
- NCO: when enable==1, each cycle {tick, acc} <= acc + inc_q. The sum is ACC_W+1 bits, and the carry becomes tick.
  - Tick rate = f_ref * inc_q / 2^ACC_W.
  - mclk toggles on every tick.
- BCLK: div_cnt counts ticks 0..MCLK_PER_BCLK-1.
  - On a tick with div_cnt==MCLK_PER_BCLK-1: div_cnt wraps to 0 and bclk toggles.
- bclk_fall asserts in the same cycle bclk goes 1->0. It is registered together with bclk.
- LRCLK: bit_cnt (0..2*SLOT_W-1) increments on each bclk_fall and wraps to 0.
  - lrclk = 0 while bit_cnt < SLOT_W, else 1.
  - lrclk is updated in the same cycle as bit_cnt, so it changes coincident with the bclk falling edge.
- frame_start = bclk_fall && (next bit_cnt == 0).
- The first frame_start after enable rises occurs at the first bclk_fall. bit_cnt is preloaded to 2*SLOT_W-1 on stop and reset.
- Increment load: on inc_load, inc_q <= inc_in.
  - The accumulate in that same cycle uses the old inc_q; the new value applies from the next cycle.
  - acc, div_cnt, bit_cnt and phase are not disturbed (glitch-free rate change).
  - lock_cnt clears and locked drops to 0 in the cycle after the load.
- inc_q == 0: no ticks, and all clocks hold their current level. locked is forced to 0.
- locked: lock_cnt increments on frame_start, saturating at LOCK_FRAMES.
  - locked = (lock_cnt == LOCK_FRAMES) && enable && (inc_q != 0).
- Stop (enable==0):
  - Next edge clears acc and div_cnt, preloads bit_cnt, and clears lock_cnt.
  - mclk/bclk/lrclk/pulses/locked go 0.
  - inc_q is retained, and inc_load is still honoured while stopped.
- Restart: same sequence as from reset, except with the retained inc_q.
- Simultaneous events:
  - rst has priority over everything.
  - enable==0 has priority over tick.
  - inc_load together with frame_start: lock_cnt clears (load wins).
- Latency, enable rise to first mclk toggle: ceil(2^ACC_W / inc_q) cycles.

Optional Feature:
- Macro AUDIO_CLK_FRAME_CNT_EN.
- Defined: an extra output port frame_cnt (16 bits) increments on each frame_start and wraps 0xFFFF->0. It is cleared by reset and by stop; it is not cleared by inc_load.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset default: hold rst=0 for 3 cycles -> all outputs 0. inc_q == 3166593488; read back via hierarchy.
- Fixed rate: ACC_W=32, load inc=0x80000000, enable=1.
  - tick every 2nd cycle, mclk period 4 cycles.
  - bclk period 16 cycles.
  - lrclk period 1024 cycles, with 512 low / 512 high.
  - frame_start every 1024 cycles.
  - locked rises right after the 2nd frame_start.
- Rate change mid-frame: switch to 0x40000000 while running.
  - mclk period becomes 8 cycles from the next tick.
  - no runt pulse on bclk or lrclk.
  - locked drops 1 cycle after the load, and returns after 2 further frames.
- Stop/restart: deassert enable mid-frame.
  - next cycle all outputs 0.
  - re-enable -> first bclk_fall coincides with frame_start, lrclk=0.
- Zero increment: load 0 while running -> mclk/bclk/lrclk frozen, locked=0. Load 0x80000000 -> clocks resume.
- AUDIO_CLK_FRAME_CNT_EN defined: run 3 frames -> frame_cnt==3. Stop -> 0. Force the count to 0xFFFF -> next frame_start wraps it to 0.
